// File: rtl/imem_arb_pkg.sv
// imem_arb_pkg: shared widths, grant encoding and types for the instruction ROM arbiter.
package imem_arb_pkg;
    localparam int DEF_ADDR_W = 15;
    localparam int DEF_DATA_W = 20;
    typedef enum logic [1:0] {GNT_NONE, GNT_FETCH, GNT_DBG} gnt_e;
    typedef enum logic {ST_IDLE, ST_WAIT} wait_st_e;
    typedef logic [DEF_ADDR_W-1:0] addr_t;
    typedef logic [DEF_DATA_W-1:0] instr_t;
endpackage

// File: rtl/imem_arb_starve_ctr.sv
// imem_arb_starve_ctr: counts consecutive denied debug cycles and flags a forced debug grant.
module imem_arb_starve_ctr
    import imem_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic req,
    input  logic gnt,
    output logic force_gnt
);
    wait_st_e st, st_n;
    logic [3:0] cnt, cnt_n;
    always_ff @(posedge clk) begin
        if (!reset) begin
            st  <= ST_IDLE;
            cnt <= '0;
        end else begin
            st  <= st_n;
            cnt <= cnt_n;
        end
    end
    always_comb begin
        force_gnt = cnt == 4'(MAX_WAIT);
        st_n      = (req && !gnt) ? ST_WAIT : ST_IDLE;
        cnt_n     = (st_n == ST_WAIT) ? (force_gnt ? cnt : cnt + 4'd1) : '0;
    end
endmodule

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one combinational ROM between fetch and debug with 1-cycle registered reads.
// Define IMEM_ARB_STATS_EN to enable the saturating grant counters.
module imem_arbiter
    import imem_arb_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = 512,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_gnt,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_data,
    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic              dbg_gnt,
    output logic              dbg_valid,
    output logic [DATA_W-1:0] dbg_data,
    output logic              oor_err,
    output logic [ADDR_W-1:0] mem_a,
    input  logic [DATA_W-1:0] mem_rd,
    output logic [15:0]       stat_fetch_cnt,
    output logic [15:0]       stat_dbg_cnt
);
    gnt_e sel;
    logic force_gnt, oor;
    logic [DATA_W-1:0] rd;
    imem_arb_starve_ctr #(.MAX_WAIT(MAX_WAIT)) u_starve (
        .clk(clk),
        .reset(reset),
        .req(dbg_req),
        .gnt(dbg_gnt),
        .force_gnt(force_gnt)
    );
    always_comb begin
        dbg_gnt   = reset && dbg_req && (!fetch_req || force_gnt);
        fetch_gnt = reset && fetch_req && !dbg_gnt;
        sel       = dbg_gnt ? GNT_DBG : fetch_gnt ? GNT_FETCH : GNT_NONE;
        mem_a     = (sel == GNT_DBG) ? dbg_addr : (sel == GNT_FETCH) ? fetch_addr : '0;
        oor       = 32'(mem_a) >= 32'(DEPTH);
        rd        = oor ? '0 : mem_rd;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_valid <= 1'b0;
            fetch_data  <= '0;
            dbg_valid   <= 1'b0;
            dbg_data    <= '0;
            oor_err     <= 1'b0;
        end else begin
            fetch_valid <= sel == GNT_FETCH;
            dbg_valid   <= sel == GNT_DBG;
            oor_err     <= (sel != GNT_NONE) && oor;
            if (sel == GNT_FETCH) fetch_data <= rd;
            if (sel == GNT_DBG) dbg_data <= rd;
        end
    end
`ifdef IMEM_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            stat_fetch_cnt <= '0;
            stat_dbg_cnt   <= '0;
        end else begin
            if (fetch_gnt && stat_fetch_cnt != 16'hFFFF) stat_fetch_cnt <= stat_fetch_cnt + 16'd1;
            if (dbg_gnt && stat_dbg_cnt != 16'hFFFF) stat_dbg_cnt <= stat_dbg_cnt + 16'd1;
        end
    end
`else
    assign stat_fetch_cnt = '0;
    assign stat_dbg_cnt   = '0;
`endif
endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: table-driven checks of grants, read data, starvation limit, range errors and reset.
module tb_imem_arbiter;
    logic clk, reset, fetch_req, dbg_req, fetch_gnt, dbg_gnt, fetch_valid, dbg_valid, oor_err;
    logic [14:0] fetch_addr, dbg_addr, mem_a;
    logic [19:0] fetch_data, dbg_data, mem_rd;
    logic [15:0] stat_fetch_cnt, stat_dbg_cnt;
    logic [19:0] rom [512];
    int n_cmp = 0;
    int n_bad = 0;

    imem_arbiter dut (
        .clk(clk), .reset(reset),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
        .fetch_valid(fetch_valid), .fetch_data(fetch_data),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_gnt(dbg_gnt),
        .dbg_valid(dbg_valid), .dbg_data(dbg_data), .oor_err(oor_err),
        .mem_a(mem_a), .mem_rd(mem_rd),
        .stat_fetch_cnt(stat_fetch_cnt), .stat_dbg_cnt(stat_dbg_cnt)
    );

    // ROM model: word i holds 0x30000+i except word 3; beyond 511 it returns garbage
    assign mem_rd = (mem_a < 15'd512) ? rom[mem_a[8:0]] : 20'hFFFFF;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic r, fr;
        logic [14:0] fa;
        logic dr;
        logic [14:0] da;
        logic fg, dg;
        logic [14:0] ma;
        logic fv;
        logic [19:0] fd;
        logic dv;
        logic [19:0] dd;
        logic oor;
    } vec_t;

    function automatic vec_t mk(logic r, logic fr, logic [14:0] fa, logic dr, logic [14:0] da,
                                logic fg, logic dg, logic [14:0] ma,
                                logic fv, logic [19:0] fd, logic dv, logic [19:0] dd, logic oor);
        vec_t v;
        v = '{r, fr, fa, dr, da, fg, dg, ma, fv, fd, dv, dd, oor};
        return v;
    endfunction

    task automatic chk(string n, int i, logic [31:0] a, logic [31:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %h want %h", n, i, a, e);
        end
    endtask

    task automatic drive(logic r, logic fr, logic [14:0] fa, logic dr, logic [14:0] da);
        @(negedge clk);
        reset = r; fetch_req = fr; fetch_addr = fa; dbg_req = dr; dbg_addr = da;
    endtask

    vec_t v [22];

    initial begin
        for (int i = 0; i < 512; i++) rom[i] = 20'h30000 + 20'(i);
        rom[3] = 20'hABCDE;
        reset = 1'b0; fetch_req = 1'b0; dbg_req = 1'b0; fetch_addr = '0; dbg_addr = '0;
        //          r  fr fa    dr da     fg dg ma     fv fd         dv dd         oor
        v[0]  = mk(0, 1, 3,    1, 7,     0, 0, 0,     0, 20'h0,     0, 20'h0,     0);
        v[1]  = mk(1, 1, 3,    0, 7,     1, 0, 3,     1, 20'hABCDE, 0, 20'h0,     0);
        v[2]  = mk(1, 1, 0,    1, 7,     1, 0, 0,     1, 20'h30000, 0, 20'h0,     0);
        v[3]  = mk(1, 1, 1,    1, 7,     1, 0, 1,     1, 20'h30001, 0, 20'h0,     0);
        v[4]  = mk(1, 1, 2,    1, 7,     1, 0, 2,     1, 20'h30002, 0, 20'h0,     0);
        v[5]  = mk(1, 1, 3,    1, 7,     1, 0, 3,     1, 20'hABCDE, 0, 20'h0,     0);
        v[6]  = mk(1, 1, 5,    1, 7,     0, 1, 7,     0, 20'hABCDE, 1, 20'h30007, 0);
        v[7]  = mk(1, 1, 5,    0, 7,     1, 0, 5,     1, 20'h30005, 0, 20'h30007, 0);
        v[8]  = mk(1, 0, 5,    1, 600,   0, 1, 600,   0, 20'h30005, 1, 20'h0,     1);
        v[9]  = mk(1, 0, 5,    0, 600,   0, 0, 0,     0, 20'h30005, 0, 20'h0,     0);
        v[10] = mk(1, 0, 5,    1, 511,   0, 1, 511,   0, 20'h30005, 1, 20'h301FF, 0);
        v[11] = mk(1, 0, 5,    1, 512,   0, 1, 512,   0, 20'h30005, 1, 20'h0,     1);
        v[12] = mk(1, 1, 2,    1, 7,     1, 0, 2,     1, 20'h30002, 0, 20'h0,     0);
        v[13] = mk(1, 1, 2,    1, 7,     1, 0, 2,     1, 20'h30002, 0, 20'h0,     0);
        v[14] = mk(1, 1, 2,    1, 7,     1, 0, 2,     1, 20'h30002, 0, 20'h0,     0);
        v[15] = mk(1, 1, 2,    0, 7,     1, 0, 2,     1, 20'h30002, 0, 20'h0,     0);
        v[16] = mk(1, 1, 2,    1, 7,     1, 0, 2,     1, 20'h30002, 0, 20'h0,     0);
        v[17] = mk(1, 1, 2,    1, 7,     1, 0, 2,     1, 20'h30002, 0, 20'h0,     0);
        v[18] = mk(1, 0, 2,    0, 7,     0, 0, 0,     0, 20'h30002, 0, 20'h0,     0);
        v[19] = mk(1, 1, 5,    0, 7,     1, 0, 5,     1, 20'h30005, 0, 20'h0,     0);
        v[20] = mk(0, 1, 5,    1, 7,     0, 0, 0,     0, 20'h0,     0, 20'h0,     0);
        v[21] = mk(1, 0, 5,    0, 7,     0, 0, 0,     0, 20'h0,     0, 20'h0,     0);
        drive(0, 0, 0, 0, 0);
        @(posedge clk);
        for (int i = 0; i < 22; i++) begin
            drive(v[i].r, v[i].fr, v[i].fa, v[i].dr, v[i].da);
            #1;
            chk("fetch_gnt", i, 32'(fetch_gnt), 32'(v[i].fg));
            chk("dbg_gnt", i, 32'(dbg_gnt), 32'(v[i].dg));
            chk("mem_a", i, 32'(mem_a), 32'(v[i].ma));
            @(posedge clk);
            #1;
            chk("fetch_valid", i, 32'(fetch_valid), 32'(v[i].fv));
            chk("fetch_data", i, 32'(fetch_data), 32'(v[i].fd));
            chk("dbg_valid", i, 32'(dbg_valid), 32'(v[i].dv));
            chk("dbg_data", i, 32'(dbg_data), 32'(v[i].dd));
            chk("oor_err", i, 32'(oor_err), 32'(v[i].oor));
        end
        // grants stay low across a multi-cycle reset even with both requesting
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 4, 1, 9);
            #1;
            chk("rst_gnts", i, {30'd0, fetch_gnt, dbg_gnt}, 32'd0);
        end
        @(posedge clk);
        #1;
        chk("rst_stat_f", 0, 32'(stat_fetch_cnt), 32'd0);
        chk("rst_stat_d", 0, 32'(stat_dbg_cnt), 32'd0);
        for (int i = 0; i < 10; i++) drive(1, 1, 15'(i), 0, 0);
        for (int i = 0; i < 3; i++) drive(1, 0, 0, 1, 15'(i));
        drive(1, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk("dbg_data_last", 0, 32'(dbg_data), 32'h30002);
`ifdef IMEM_ARB_STATS_EN
        chk("stat_fetch_cnt", 0, 32'(stat_fetch_cnt), 32'd10);
        chk("stat_dbg_cnt", 0, 32'(stat_dbg_cnt), 32'd3);
`else
        chk("stat_fetch_cnt", 0, 32'(stat_fetch_cnt), 32'd0);
        chk("stat_dbg_cnt", 0, 32'(stat_dbg_cnt), 32'd0);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Shares the single combinational instruction ROM (15-bit address, 20-bit word) between two requesters:
  - the pipeline fetch port (PCF side);
  - a debug/readback port (program dump, display, loader verify).
- Fixed fetch priority, with a starvation limit for the debug port.
- Registers the selected ROM word, so both ports see a 1-cycle read latency.
- Sits between the fetch stage and the instruction memory; drives the ROM address directly.

Parameters:
- ADDR_W, 15, address width; matches the ROM address port.
- DATA_W, 20, instruction width.
- DEPTH, 512, implemented ROM words; addresses >= DEPTH are out of range.
- MAX_WAIT, 4, consecutive denied debug-request cycles before debug is forced a grant (1..15).

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  synchronous, active-low reset.
- fetch_req  input  1  fetch read request; held until fetch_gnt.
- fetch_addr  input  ADDR_W  fetch word address; sampled in grant cycle.
- fetch_gnt  output  1  combinational grant to fetch this cycle.
- fetch_valid  output  1  fetch_data valid (cycle after grant).
- fetch_data  output  DATA_W  registered instruction word for fetch.
- dbg_req  input  1  debug read request; held until dbg_gnt.
- dbg_addr  input  ADDR_W  debug word address.
- dbg_gnt  output  1  combinational grant to debug.
- dbg_valid  output  1  dbg_data valid.
- dbg_data  output  DATA_W  registered word for debug.
- oor_err  output  1  pulses with a valid when the serviced address was >= DEPTH.
- mem_a  output  ADDR_W  address to instruction ROM.
- mem_rd  input  DATA_W  ROM read data (combinational from mem_a).
- stat_fetch_cnt  output  16  fetch grant count (optional feature).
- stat_dbg_cnt  output  16  debug grant count (optional feature).

Behaviour:
- Reset (reset==0 at a clk edge) clears all of the following:
  - every registered output: *_valid, *_data, oor_err, and the stat counters;
  - the wait counter (reset to 0).
- While reset==0, both grants are forced low and mem_a = 0.
- Grants are one-hot or zero. At most one grant per cycle:
  - dbg_gnt = dbg_req & (~fetch_req | wait_cnt == MAX_WAIT);
  - fetch_gnt = fetch_req & ~dbg_gnt.
- mem_a = granted port's address; 0 when there is no grant.
- Read timing:
  - Edge after a grant: the granted port's *_data <= mem_rd (or 0 if out of range) and its *_valid <= 1.
  - The other port's valid <= 0; its data holds its last value.
  - With no grant, both valids <= 0.
- Latency: exactly 1 cycle from the grant cycle to valid. Back-to-back grants sustain 1 word/cycle.
- Out-of-range access:
  - address >= DEPTH returns data 0 and oor_err=1 in the same cycle as the valid;
  - the ROM is still addressed but its output is ignored.
- Wait counter (the 2-state FSM):
  - WAITING: dbg_req & ~dbg_gnt increments wait_cnt, saturating at MAX_WAIT.
  - SERVED/IDLE: dbg_gnt or ~dbg_req clears wait_cnt to 0.
  - Forced debug grant when wait_cnt == MAX_WAIT; fetch is denied that cycle and must hold its request.
- Simultaneous requests below the limit: fetch wins.
- Requester dropping req without a grant: legal, no side effects; the wait counter clears.
- Reset asserted mid-operation: the in-flight valid is dropped next edge; no stale data is presented after reset release.

Optional Feature:
- Macro: IMEM_ARB_STATS_EN.
- Defined:
  - stat_fetch_cnt and stat_dbg_cnt count grants (fetch_gnt and dbg_gnt respectively);
  - 16-bit, saturating at 16'hFFFF;
  - cleared by reset.
- Undefined: both ports are tied to 0 and no counter flops are inferred. The port list is unchanged.

Decomposition:
- Package imem_arb_pkg holds:
  - ADDR_W/DATA_W defaults;
  - typedef enum logic [1:0] {GNT_NONE, GNT_FETCH, GNT_DBG} gnt_e;
  - typedefs addr_t and instr_t.
- One sub-module: imem_arb_starve_ctr (wait counter + force flag, parameterised by MAX_WAIT).
- The stats counters stay inline under the macro.

Test Plan:
- Reset then release with ROM[3]=20'hABCDE: fetch_req=1, fetch_addr=3 -> fetch_gnt same cycle; next cycle fetch_valid=1, fetch_data=20'hABCDE, dbg_valid=0.
- fetch_req held high, dbg_req=1 addr=7, MAX_WAIT=4 -> dbg denied 4 cycles; dbg_gnt on 5th cycle with fetch_gnt=0; dbg_data=ROM[7] next cycle; fetch granted again the following cycle.
- Alternating addresses 0,1,2,3 on fetch every cycle -> four consecutive fetch_valid cycles with data ROM[0..3] in order.
- dbg_addr=600 (DEPTH=512), fetch idle -> dbg_valid=1, dbg_data=0, oor_err=1 for one cycle.
- Grant at addr 5, reset driven low the next cycle -> fetch_valid=0 and fetch_data=0 after that edge; grants low for the whole reset.
- With IMEM_ARB_STATS_EN: 10 fetch grants + 3 debug grants -> stat_fetch_cnt=10, stat_dbg_cnt=3. Without the macro both read 0.
